focus_pwm_driver: RTL and testbench
===================================

# focus_pwm_driver

Converts the 8-bit offset-binary drive command from the focus PID loop into complementary-safe H-bridge PWM for the focus actuator. Code 128 means zero drive; codes above 128 drive forward on `drive_a`, codes below 128 drive reverse on `drive_b`. Duty updates are double-buffered and take effect only at PWM period boundaries. Every direction change, and every start from idle, inserts a dead time with both outputs low.

## Interface
- `PRESCALE`, default 4: clk cycles per PWM tick, ≥1; PWM period = 256·PRESCALE clk cycles.
- `DEAD_CYCLES`, default 8: clk cycles with both outputs low before entering either drive state; 1 ≤ DEAD_CYCLES < 256·PRESCALE.
- `clk`  in  1  system clock (5 MHz slow domain)
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  drive enable; low forces outputs low
- `duty_in`  in  8  offset-binary command, 128 = zero
- `duty_valid`  in  1  single-cycle strobe; loads `duty_in` into the shadow register
- `drive_a`  out  1  forward H-bridge leg (registered)
- `drive_b`  out  1  reverse H-bridge leg (registered)
- `period_start`  out  1  one-cycle pulse on the first cycle of each PWM period (registered)

## Operation
- **Prescaler and period counter**
  - Prescaler `pre` counts 0..PRESCALE-1.
  - 8-bit tick counter `cnt` increments when `pre` wraps, and wraps 255→0.
  - Period boundary = the cycle where `pre`==0 and `cnt`==0.
- **Duty buffering**
  - `duty_valid` writes `shadow <= duty_in`.
  - At each period boundary, `active <= shadow`.
  - If `duty_valid` coincides with a boundary, `duty_in` bypasses into `active` directly.
- **Decode**
  - `cmd = active - 128` (signed 9-bit, range -128..+127).
  - `dir = cmd<0`.
  - `mag = |cmd|` (0..128).
  - PWM compare: `pwm_on = ({1'b0,cnt} < 2·mag)`, 9-bit compare.
  - mag 128 is continuously on; mag 0 is continuously off.
- **States:** IDLE, DEAD, FWD, REV.
  - IDLE: both outputs 0. Goes to DEAD when enabled and mag≠0, with target = dir.
  - DEAD: both outputs 0; a down-counter loaded with DEAD_CYCLES. When the counter expires, go to FWD if target=0, otherwise REV.
  - FWD: `drive_a = pwm_on`, `drive_b = 0`.
  - REV: `drive_a = 0`, `drive_b = pwm_on`.
  - From FWD/REV, evaluated at period boundaries only:
    - mag==0 → IDLE.
    - dir differs from the current state → DEAD with the new target.
    - otherwise stay.
  - The period counter runs through DEAD. The first drive period after DEAD is therefore truncated; the outputs follow the compare for the remainder of that period.
- **Enable**
  - While `enable`=0: `pre`=`cnt`=0, state=IDLE, outputs 0, `active` tracks `shadow` (and the bypass when `duty_valid` is high).
  - The first cycle after `enable` rises is a period boundary.
- **Invariant:** `drive_a` and `drive_b` are never high in the same cycle. A direction change always has ≥DEAD_CYCLES cycles of both outputs low.

## Timing
- **Reset values:** `shadow`=`active`=128, `pre`=`cnt`=0, state IDLE, `drive_a`=`drive_b`=`period_start`=0.
- **Reset mid-operation:** outputs go low on the next edge; no dead time is owed on release, because the subsequent IDLE→DEAD path provides it.
- `period_start` is high in the clk cycle after the boundary condition, aligned with the first output cycle of that period.
- **Duty latency:** a `duty_valid` accepted before a boundary appears on the outputs 1 clk after that boundary (registered outputs). Maximum latency is 256·PRESCALE+1 cycles.
- **DEAD duration:** exactly DEAD_CYCLES clk cycles of both outputs low, measured on the outputs.
- **Disable:** deasserting `enable` forces both outputs low on the next clk edge, regardless of state.
- **Duty step sizes:** with PRESCALE=4, each step of `mag` changes the high time by 2 ticks = 8 clk cycles.

## Test plan
- **Idle after reset:** reset, `enable`=1, no `duty_valid` → `drive_a`=`drive_b`=0 for ≥3 periods; `period_start` every 1024 cycles.
- **Forward 50 %:** `duty_in`=192 strobed → from the next boundary, 8 cycles both low, then `drive_a` high 512−8 cycles in the truncated first period; each subsequent period has `drive_a` high 512 / low 512; `drive_b` stays 0.
- **Extremes:**
  - `duty_in`=255 → `drive_a` high 1016 of 1024 cycles.
  - `duty_in`=0 → after DEAD, `drive_b` continuously high.
  - `duty_in`=128 → IDLE at the next boundary.
- **Reversal:** steady at 192, then strobe 64 mid-period → no change until the boundary; then 8 cycles both low; then `drive_b` high 512 per period. Assert `drive_a`&`drive_b` is never 1 throughout.
- **Coincident strobe:** `duty_valid` with `duty_in`=160 on the boundary cycle → that same period uses mag 32 (`drive_a` high 256 cycles); the earlier shadow value is never output.
- **Enable toggle:** drop `enable` while `drive_a` is high → 0 on the next edge. Re-raise `enable` → `period_start` 1 cycle later, 8 cycles both low, then drive resumes.

Source files
------------

// File: rtl/focus_pwm_driver.sv
// Focus actuator H-bridge PWM driver: offset-binary duty (128 = zero) to a
// forward/reverse leg pair with dead time on every start and direction change.
module focus_pwm_driver #(
    parameter int PRESCALE    = 4,
    parameter int DEAD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       drive_a,
    output logic       drive_b,
    output logic       period_start
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(256 * PRESCALE);
    localparam logic [PW-1:0] PRE_ZERO  = PW'(0);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_ONE  = DW'(1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEAD = 2'd1,
        S_FWD  = 2'd2,
        S_REV  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    active_q, active_d;
    logic [DW-1:0] dead_q, dead_d;
    logic          target_rev_q, target_rev_d;
    logic          drive_a_q, drive_a_d;
    logic          drive_b_q, drive_b_d;
    logic          period_start_q, period_start_d;

    logic          boundary_s;
    logic          dir_rev_s;
    logic [7:0]    mag_s;
    logic          pwm_on_s;

    // Duty buffering and decode; at a boundary the freshly loaded value is used at once.
    always_comb begin
        boundary_s = enable && (pre_q == PRE_ZERO) && (cnt_q == 8'd0);
        shadow_d   = duty_valid ? duty_in : shadow_q;
        if (!enable || boundary_s) begin
            active_d = duty_valid ? duty_in : shadow_q;
        end else begin
            active_d = active_q;
        end
        dir_rev_s = ~active_d[7];
        mag_s     = active_d[7] ? {1'b0, active_d[6:0]} : (8'd128 - active_d);
        pwm_on_s  = ({1'b0, cnt_q} < {mag_s, 1'b0});
    end

    // Prescaler and tick counter, parked at zero while disabled.
    always_comb begin
        if (!enable) begin
            pre_d = PRE_ZERO;
            cnt_d = 8'd0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = PRE_ZERO;
            cnt_d = cnt_q + 8'd1;
        end else begin
            pre_d = pre_q + PRE_ONE;
            cnt_d = cnt_q;
        end
    end

    // Drive state machine; drive states only re-evaluate the command at period boundaries.
    always_comb begin
        state_d      = state_q;
        dead_d       = dead_q;
        target_rev_d = target_rev_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mag_s != 8'd0) begin
                        state_d      = S_DEAD;
                        dead_d       = DEAD_LOAD;
                        target_rev_d = dir_rev_s;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DEAD: begin
                    if (dead_q == DEAD_ONE) begin
                        state_d = target_rev_q ? S_REV : S_FWD;
                    end else begin
                        dead_d = dead_q - DEAD_ONE;
                    end
                end
                S_FWD, S_REV: begin
                    if (!boundary_s) begin
                        state_d = state_q;
                    end else if (mag_s == 8'd0) begin
                        state_d = S_IDLE;
                    end else if (dir_rev_s != (state_q == S_REV)) begin
                        state_d      = S_DEAD;
                        dead_d       = DEAD_LOAD;
                        target_rev_d = dir_rev_s;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs follow the next state so dead time is measured exactly on the pins.
    always_comb begin
        drive_a_d      = (state_d == S_FWD) && pwm_on_s;
        drive_b_d      = (state_d == S_REV) && pwm_on_s;
        period_start_d = boundary_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pre_q          <= PRE_ZERO;
            cnt_q          <= 8'd0;
            shadow_q       <= 8'd128;
            active_q       <= 8'd128;
            dead_q         <= DEAD_LOAD;
            target_rev_q   <= 1'b0;
            drive_a_q      <= 1'b0;
            drive_b_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            dead_q         <= dead_d;
            target_rev_q   <= target_rev_d;
            drive_a_q      <= drive_a_d;
            drive_b_q      <= drive_b_d;
            period_start_q <= period_start_d;
        end
    end

    assign drive_a      = drive_a_q;
    assign drive_b      = drive_b_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_focus_pwm_driver.sv
// Self-checking bench for focus_pwm_driver: directed scenarios plus random
// strobes/enables/resets against a cycle-level reference of the drive rules.
module tb_focus_pwm_driver;
    localparam int PRESCALE = 4;
    localparam int DEAD     = 8;
    localparam int PERIOD   = 256 * PRESCALE;
    localparam int M_IDLE = 0, M_DEAD = 1, M_FWD = 2, M_REV = 3;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       enable     = 1'b0;
    logic       duty_valid = 1'b0;
    logic [7:0] duty_in    = 8'd128;
    logic       drive_a, drive_b, period_start;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  mdl_err = 0;
    int  ovl_cnt = 0;
    time first_err_t = 0;

    int  m_shadow, m_active, m_pos, m_mode, m_left;
    bit  m_tgt_rev;
    logic exp_a, exp_b, exp_ps;

    int w_ha[4], w_hb[4];
    int w_pre_a, w_pre_b, w_tot_a, w_tot_b, w_nps, w_first_ps, w_last_ps, w_lead;

    focus_pwm_driver #(.PRESCALE(PRESCALE), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .duty_in(duty_in),
        .duty_valid(duty_valid), .drive_a(drive_a), .drive_b(drive_b),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Reference: duty buffering, direction/magnitude and dead-time rules per clock.
    always @(posedge clk) begin : ref_model
        int act, mag, nxt, left;
        bit bnd, rev, on, tgt;
        if (reset) begin
            m_shadow <= 128; m_active <= 128; m_pos <= 0; m_mode <= M_IDLE;
            m_left <= 0; m_tgt_rev <= 1'b0;
            exp_a <= 1'b0; exp_b <= 1'b0; exp_ps <= 1'b0;
        end else begin
            bnd = enable && (m_pos == 0);
            act = (!enable || bnd) ? (duty_valid ? int'(duty_in) : m_shadow) : m_active;
            rev = (act < 128);
            mag = rev ? 128 - act : act - 128;
            on  = ((m_pos / PRESCALE) < 2 * mag);
            nxt = m_mode; left = m_left; tgt = m_tgt_rev;
            if (!enable) begin
                nxt = M_IDLE;
            end else if (m_mode == M_IDLE) begin
                if (mag != 0) begin nxt = M_DEAD; left = DEAD; tgt = rev; end
            end else if (m_mode == M_DEAD) begin
                left = m_left - 1;
                if (left == 0) nxt = m_tgt_rev ? M_REV : M_FWD;
            end else if (bnd) begin
                if (mag == 0) nxt = M_IDLE;
                else if (rev != (m_mode == M_REV)) begin nxt = M_DEAD; left = DEAD; tgt = rev; end
            end
            m_active  <= act;
            m_shadow  <= duty_valid ? int'(duty_in) : m_shadow;
            m_mode    <= nxt;
            m_left    <= left;
            m_tgt_rev <= tgt;
            m_pos     <= enable ? (m_pos + 1) % PERIOD : 0;
            exp_a     <= (nxt == M_FWD) && on;
            exp_b     <= (nxt == M_REV) && on;
            exp_ps    <= bnd;
        end
    end

    // Tally cycles where the outputs disagree with the reference or both legs are on.
    always @(negedge clk) begin : scoreboard
        if ({drive_a, drive_b, period_start} !== {exp_a, exp_b, exp_ps}) begin
            if (mdl_err == 0) first_err_t <= $time;
            mdl_err <= mdl_err + 1;
        end
        if (drive_a && drive_b) ovl_cnt <= ovl_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Run n cycles (optionally strobing val in the first) and collect per-period statistics.
    task automatic watch(input int n, input bit do_strobe, input logic [7:0] val);
        int  p;
        bit  got;
        p = -1; got = 1'b0;
        w_pre_a = 0; w_pre_b = 0; w_tot_a = 0; w_tot_b = 0;
        w_nps = 0; w_first_ps = -1; w_last_ps = -1; w_lead = -1;
        for (int k = 0; k < 4; k++) begin w_ha[k] = 0; w_hb[k] = 0; end
        if (do_strobe) begin duty_in = val; duty_valid = 1'b1; end
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            duty_valid = 1'b0;
            if (period_start === 1'b1) begin
                p++; w_nps++; w_last_ps = c;
                if (w_first_ps < 0) w_first_ps = c;
            end
            w_tot_a += int'(drive_a === 1'b1);
            w_tot_b += int'(drive_b === 1'b1);
            if (p < 0) begin
                w_pre_a += int'(drive_a === 1'b1);
                w_pre_b += int'(drive_b === 1'b1);
            end else if (p < 4) begin
                w_ha[p] += int'(drive_a === 1'b1);
                w_hb[p] += int'(drive_b === 1'b1);
            end
            if (w_first_ps >= 0 && !got && (drive_a === 1'b1 || drive_b === 1'b1)) begin
                got = 1'b1; w_lead = c - w_first_ps;
            end
        end
        #1;
    endtask

    // Advance to the negedge just before the cycle with phase p.
    task automatic goto_pos(input int p);
        for (int i = 0; i < PERIOD + 2 && m_pos != p; i++) @(negedge clk);
    endtask

    function automatic logic [7:0] pick_duty();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd128;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; duty_valid = 1'b0; duty_in = 8'd200;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({drive_a, drive_b, period_start} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outputs: got a/b/ps=%b%b%b want 000", drive_a, drive_b, period_start);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (period_start !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_boundary: period_start=%b want 1", period_start);
        end
        n_tests++;
        if ({drive_a, drive_b} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle: got a/b=%b%b want 00", drive_a, drive_b);
        end
        #1;
    endtask

    task automatic test_idle();
        int m0 = mdl_err;
        watch(3 * PERIOD, 1'b0, 8'd0);
        n_tests++;
        if (w_nps != 3 || (w_last_ps - w_first_ps) != 2 * PERIOD) begin
            n_fail++; $display("FAIL idle_period_start: pulses=%0d span=%0d want 3 and %0d", w_nps, w_last_ps - w_first_ps, 2 * PERIOD);
        end
        n_tests++;
        if (w_tot_a + w_tot_b != 0) begin
            n_fail++; $display("FAIL idle_outputs: high cycles a=%0d b=%0d want 0", w_tot_a, w_tot_b);
        end
        n_tests++;
        if (mdl_err !== m0) begin
            n_fail++; $display("FAIL idle_model: %0d cycles disagree, first at %0t", mdl_err - m0, first_err_t);
        end
    endtask

    task automatic test_forward50();
        int m0 = mdl_err;
        goto_pos($urandom_range(100, 900));
        watch(3 * PERIOD, 1'b1, 8'd192);
        n_tests++;
        if (w_pre_a != 0 || w_lead != DEAD) begin
            n_fail++; $display("FAIL fwd50_dead: pre-boundary highs=%0d lead=%0d want 0 and %0d", w_pre_a, w_lead, DEAD);
        end
        n_tests++;
        if (w_ha[0] != 512 - DEAD || w_ha[1] != 512) begin
            n_fail++; $display("FAIL fwd50_high: first=%0d next=%0d want %0d and 512", w_ha[0], w_ha[1], 512 - DEAD);
        end
        n_tests++;
        if (w_tot_b != 0) begin
            n_fail++; $display("FAIL fwd50_b_quiet: drive_b high %0d cycles want 0", w_tot_b);
        end
        n_tests++;
        if (mdl_err !== m0) begin
            n_fail++; $display("FAIL fwd50_model: %0d cycles disagree, first at %0t", mdl_err - m0, first_err_t);
        end
    endtask

    task automatic test_extremes();
        int m0 = mdl_err;
        int p;
        goto_pos($urandom_range(100, 900));
        watch(3 * PERIOD, 1'b1, 8'd255);
        n_tests++;
        if (w_ha[0] != 1016 || w_ha[1] != 1016) begin
            n_fail++; $display("FAIL ext255_high: %0d/%0d want 1016/1016", w_ha[0], w_ha[1]);
        end
        goto_pos($urandom_range(100, 900));
        watch(3 * PERIOD, 1'b1, 8'd0);
        n_tests++;
        if (w_lead != DEAD || w_hb[0] != PERIOD - DEAD || w_hb[1] != PERIOD || w_ha[0] != 0) begin
            n_fail++; $display("FAIL ext0_reverse: lead=%0d b=%0d/%0d a=%0d want %0d %0d/%0d 0",
                               w_lead, w_hb[0], w_hb[1], w_ha[0], DEAD, PERIOD - DEAD, PERIOD);
        end
        p = $urandom_range(100, 900);
        goto_pos(p);
        watch(3 * PERIOD, 1'b1, 8'd128);
        n_tests++;
        if (w_pre_b != PERIOD - p || w_hb[0] != 0 || w_hb[1] != 0 || w_tot_a != 0) begin
            n_fail++; $display("FAIL ext128_idle: pre_b=%0d b=%0d/%0d a=%0d want %0d 0/0 0",
                               w_pre_b, w_hb[0], w_hb[1], w_tot_a, PERIOD - p);
        end
        n_tests++;
        if (mdl_err !== m0) begin
            n_fail++; $display("FAIL extremes_model: %0d cycles disagree, first at %0t", mdl_err - m0, first_err_t);
        end
    endtask

    task automatic test_reversal();
        int m0 = mdl_err;
        int o0 = ovl_cnt;
        int p;
        watch(3 * PERIOD, 1'b1, 8'd192);
        p = $urandom_range(200, 800);
        goto_pos(p);
        watch(3 * PERIOD, 1'b1, 8'd64);
        n_tests++;
        if (w_pre_a != ((p < 512) ? 512 - p : 0) || w_pre_b != 0) begin
            n_fail++; $display("FAIL rev_before_boundary: a=%0d b=%0d want %0d 0", w_pre_a, w_pre_b, (p < 512) ? 512 - p : 0);
        end
        n_tests++;
        if (w_lead != DEAD || w_hb[0] != 512 - DEAD || w_hb[1] != 512 || w_ha[0] + w_ha[1] != 0) begin
            n_fail++; $display("FAIL rev_drive: lead=%0d b=%0d/%0d a=%0d want %0d %0d/512 0",
                               w_lead, w_hb[0], w_hb[1], w_ha[0] + w_ha[1], DEAD, 512 - DEAD);
        end
        n_tests++;
        if (ovl_cnt !== o0) begin
            n_fail++; $display("FAIL rev_overlap: both legs high %0d cycles want 0", ovl_cnt - o0);
        end
        n_tests++;
        if (mdl_err !== m0) begin
            n_fail++; $display("FAIL rev_model: %0d cycles disagree, first at %0t", mdl_err - m0, first_err_t);
        end
    endtask

    task automatic test_coincident();
        int m0 = mdl_err;
        watch(3 * PERIOD, 1'b1, 8'd192);
        goto_pos($urandom_range(300, 700));
        watch(1, 1'b1, 8'd220);
        goto_pos(0);
        watch(2 * PERIOD + 8, 1'b1, 8'd160);
        n_tests++;
        if (w_first_ps != 0) begin
            n_fail++; $display("FAIL coinc_alignment: first period_start at cycle %0d want 0", w_first_ps);
        end
        n_tests++;
        if (w_ha[0] != 256 || w_ha[1] != 256 || w_tot_b != 0) begin
            n_fail++; $display("FAIL coinc_bypass: a=%0d/%0d b=%0d want 256/256 0", w_ha[0], w_ha[1], w_tot_b);
        end
        n_tests++;
        if (mdl_err !== m0) begin
            n_fail++; $display("FAIL coinc_model: %0d cycles disagree, first at %0t", mdl_err - m0, first_err_t);
        end
    endtask

    task automatic test_enable_toggle();
        int m0 = mdl_err;
        int nd = $urandom_range(5, 50);
        int bad = 0;
        goto_pos($urandom_range(20, 200));
        n_tests++;
        if (drive_a !== 1'b1) begin
            n_fail++; $display("FAIL en_precondition: drive_a=%b want 1", drive_a);
        end
        enable = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({drive_a, drive_b} !== 2'b00) begin
            n_fail++; $display("FAIL en_drop: got a/b=%b%b want 00", drive_a, drive_b);
        end
        duty_in = 8'd192;
        for (int k = 0; k < nd; k++) begin
            duty_valid = (k == 2);
            @(negedge clk);
            if (drive_a !== 1'b0 || drive_b !== 1'b0 || period_start !== 1'b0) bad++;
        end
        duty_valid = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL en_disabled_quiet: %0d active cycles want 0", bad);
        end
        enable = 1'b1;
        watch(2 * PERIOD + 16, 1'b0, 8'd0);
        n_tests++;
        if (w_first_ps != 0 || w_lead != DEAD) begin
            n_fail++; $display("FAIL en_restart: first_ps=%0d lead=%0d want 0 %0d", w_first_ps, w_lead, DEAD);
        end
        n_tests++;
        if (w_ha[0] != 512 - DEAD || w_ha[1] != 512) begin
            n_fail++; $display("FAIL en_resume: a=%0d/%0d want %0d/512", w_ha[0], w_ha[1], 512 - DEAD);
        end
        n_tests++;
        if (mdl_err !== m0) begin
            n_fail++; $display("FAIL en_model: %0d cycles disagree, first at %0t", mdl_err - m0, first_err_t);
        end
    endtask

    task automatic test_random();
        int m0 = mdl_err;
        int o0 = ovl_cnt;
        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    enable = 1'b0;
                    watch($urandom_range(3, 40), ($urandom_range(0, 1) == 1), pick_duty());
                    enable = 1'b1;
                end
                1: begin
                    reset = 1'b1;
                    watch($urandom_range(1, 3), 1'b0, 8'd0);
                    reset = 1'b0;
                end
                default: watch($urandom_range(20, 1500), 1'b1, pick_duty());
            endcase
        end
        watch(2 * PERIOD, 1'b0, 8'd0);
        n_tests++;
        if (w_nps != 2) begin
            n_fail++; $display("FAIL rand_periods: %0d period_start pulses want 2", w_nps);
        end
        n_tests++;
        if (ovl_cnt !== o0) begin
            n_fail++; $display("FAIL rand_overlap: both legs high %0d cycles want 0", ovl_cnt - o0);
        end
        n_tests++;
        if (mdl_err !== m0) begin
            n_fail++; $display("FAIL rand_model: %0d cycles disagree, first at %0t", mdl_err - m0, first_err_t);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_forward50();
        test_extremes();
        test_reversal();
        test_coincident();
        test_enable_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
